// File: rtl/alu_display_pkg.sv
// Shared definitions for the ALU result display: segment font, digit index
// encoding and the digit-enable helper.
package alu_display_pkg;

  typedef enum logic [1:0] {
    DIGIT_0 = 2'd0,
    DIGIT_1 = 2'd1,
    DIGIT_2 = 2'd2,
    DIGIT_3 = 2'd3
  } digit_idx_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_A     = SEG_HEX_A;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] an_onehot(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// ALU-side capture inputs and board-side display pins of the result display.
interface alu_result_display_if;
  logic [0:3] s;
  logic       c_out;
  logic [0:2] op;
  logic       m;
  logic       load;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (output s, c_out, op, m, load, input seg, an, dp);
  modport slave  (input s, c_out, op, m, load, output seg, an, dp);
endinterface

// File: rtl/alu_result_display_hex_to_seg.sv
// Combinational 4-bit hex value to active-low 7-segment pattern.
module hex_to_seg
  import alu_display_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  // Font lookup
  always_comb begin
    seg_o = SEG_BLANK;
    case (value_i)
      4'h0:    seg_o = SEG_HEX_0;
      4'h1:    seg_o = SEG_HEX_1;
      4'h2:    seg_o = SEG_HEX_2;
      4'h3:    seg_o = SEG_HEX_3;
      4'h4:    seg_o = SEG_HEX_4;
      4'h5:    seg_o = SEG_HEX_5;
      4'h6:    seg_o = SEG_HEX_6;
      4'h7:    seg_o = SEG_HEX_7;
      4'h8:    seg_o = SEG_HEX_8;
      4'h9:    seg_o = SEG_HEX_9;
      4'hA:    seg_o = SEG_HEX_A;
      4'hB:    seg_o = SEG_HEX_B;
      4'hC:    seg_o = SEG_HEX_C;
      4'hD:    seg_o = SEG_HEX_D;
      4'hE:    seg_o = SEG_HEX_E;
      4'hF:    seg_o = SEG_HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result on a load strobe and shows it on a 4-digit,
// common-anode multiplexed 7-segment display with registered outputs.
module alu_result_display
  import alu_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_result_display_if.slave   bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic             valid_q;
  logic [3:0]       s_q;
  logic             c_out_q;
  logic [2:0]       op_q;
  logic             m_q;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic [3:0]       nibble_s;
  logic [6:0]       hex_seg_s;

  // Refresh counter wrap advances the digit index
  always_comb begin
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = digit_idx_t'(idx_q + 2'd1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  always_comb begin
    nibble_s = s_q;
    case (idx_q)
      DIGIT_0: nibble_s = s_q;
      DIGIT_1: nibble_s = {3'b000, c_out_q};
      DIGIT_2: nibble_s = {1'b0, op_q};
      DIGIT_3: nibble_s = 4'hA;
      default: nibble_s = s_q;
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .value_i (nibble_s),
    .seg_o   (hex_seg_s)
  );

  // Digit 3 reuses the hex 'A' glyph for arithmetic mode; only 'L' needs an override
  always_comb begin
    an_d = an_onehot(idx_q);
    if (!valid_q) begin
      seg_d = SEG_DASH;
    end else if ((idx_q == DIGIT_3) && m_q) begin
      seg_d = SEG_L;
    end else begin
      seg_d = hex_seg_s;
    end
    if (valid_q && c_out_q && (idx_q == DIGIT_0)) begin
      dp_d = 1'b0;
    end else begin
      dp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= DIGIT_0;
      valid_q <= 1'b0;
      s_q     <= 4'h0;
      c_out_q <= 1'b0;
      op_q    <= 3'h0;
      m_q     <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
      if (bus.load) begin
        valid_q <= 1'b1;
        s_q     <= bus.s;
        c_out_q <= bus.c_out;
        op_q    <= bus.op;
        m_q     <= bus.m;
      end else begin
        valid_q <= valid_q;
      end
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed plus randomized bench for alu_result_display against a
// cycle-count based reference model.
module tb_alu_result_display;

  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_result_display_if bus();

  alu_result_display #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] font [0:15];

  // Reference model state: captured data and edges since reset release
  logic       m_valid;
  logic [3:0] m_s;
  logic       m_c;
  logic [2:0] m_op;
  logic       m_m;
  int         m_cycles;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [3:0] sv,
                      input logic cv, input logic [2:0] ov, input logic mv);
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    int         dig;
    rst       = r;
    bus.load  = ld;
    bus.s     = sv;
    bus.c_out = cv;
    bus.op    = ov;
    bus.m     = mv;
    @(posedge clk);
    if (r) begin
      e_seg = 7'b1111111; e_an = 4'b1111; e_dp = 1'b1;
      m_valid = 1'b0; m_s = 4'h0; m_c = 1'b0; m_op = 3'h0; m_m = 1'b0;
      m_cycles = 0;
    end else begin
      dig  = (m_cycles / DIV) % 4;
      e_an = 4'b1111;
      e_an[dig] = 1'b0;
      e_dp = 1'b1;
      if (!m_valid) begin
        e_seg = 7'b0111111;
      end else begin
        case (dig)
          0: begin e_seg = font[m_s]; e_dp = ~m_c; end
          1: e_seg = font[{3'b000, m_c}];
          2: e_seg = font[{1'b0, m_op}];
          default: e_seg = m_m ? 7'b1000111 : 7'b0001000;
        endcase
      end
      m_cycles++;
      if (ld) begin
        m_valid = 1'b1; m_s = sv; m_c = cv; m_op = ov; m_m = mv;
      end
    end
    #1;
    chk("seg", bus.seg, e_seg);
    chk("an", {3'b000, bus.an}, {3'b000, e_an});
    chk("dp", {6'd0, bus.dp}, {6'd0, e_dp});
    if (!r) chk("an_onehot", 7'($countones(~bus.an)), 7'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
  endtask

  initial begin
    int guard;
    font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    clk = 1'b0; checks = 0; errors = 0;
    m_valid = 1'b0; m_s = 4'h0; m_c = 1'b0; m_op = 3'h0; m_m = 1'b0; m_cycles = 0;

    repeat (3) step(1'b1, 1'b0, 4'h0, 1'b0, 3'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 3'h0, 1'b0);
    chk("first_an", {3'b000, bus.an}, 7'b0001110);
    idle(31);

    // F / carry / op 5 / logic, then inputs wander without load
    step(1'b0, 1'b1, 4'b1111, 1'b1, 3'b101, 1'b1);
    idle(20);
    step(1'b0, 1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    idle(18);
    step(1'b0, 1'b1, 4'h3, 1'b0, 3'h2, 1'b0);
    step(1'b0, 1'b1, 4'h9, 1'b1, 3'h6, 1'b1);
    idle(18);

    guard = 0;
    while (((m_cycles / DIV) % 4) != 2 && guard < 32) begin
      idle(1);
      guard++;
    end
    chk("reach_digit2", {6'd0, guard < 32}, 7'd1);
    step(1'b1, 1'b1, 4'h7, 1'b1, 3'h7, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 3'h0, 1'b0);
    chk("restart_an", {3'b000, bus.an}, 7'b0001110);
    idle(10);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
           4'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
